m_seg7_scanner: RTL and testbench



---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_if.sv | 33 +++
 rtl/m_bcd_to_seg7.sv | 33 +++
 rtl/m_seg7_scanner.sv | 148 ++++++++++++++
 tb/tb_m_seg7_scanner.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// +-------------------------------------------------------------------------+
// | seg7_pkg : shared constants and types for the 7-segment scanner          |
// | Rev 1.0  : initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

package seg7_pkg;

   localparam int NUM_DIGITS = 6;

   // Active-low patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   localparam logic [5:0] DIG_OFF  = 6'h3F;

   typedef logic [2:0] slot_t;

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_if.sv
// +-------------------------------------------------------------------------+
// | seg7_if : timer digit inputs and multiplexed display outputs             |
// | Rev 1.0  : initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

interface seg7_if;
   import seg7_pkg::*;

   logic [3:0] h1;
   logic [3:0] h0;
   logic [3:0] m1;
   logic [3:0] m0;
   logic [3:0] s1;
   logic [3:0] s0;
   logic       one_hz_clk;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [5:0] dig_n;

   modport master (
      output h1, h0, m1, m0, s1, s0, one_hz_clk,
      input  seg_n, dp_n, dig_n
   );

   modport slave (
      input  h1, h0, m1, m0, s1, s0, one_hz_clk,
      output seg_n, dp_n, dig_n
   );

endinterface

`default_nettype wire

// File: rtl/m_bcd_to_seg7.sv
// +-------------------------------------------------------------------------+
// | m_bcd_to_seg7 : combinational BCD to active-low 7-segment decoder        |
// | Rev 1.0  : initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module m_bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_DASH;
      case (bcd)
         4'd0:    seg_n = SEG_0;
         4'd1:    seg_n = SEG_1;
         4'd2:    seg_n = SEG_2;
         4'd3:    seg_n = SEG_3;
         4'd4:    seg_n = SEG_4;
         4'd5:    seg_n = SEG_5;
         4'd6:    seg_n = SEG_6;
         4'd7:    seg_n = SEG_7;
         4'd8:    seg_n = SEG_8;
         4'd9:    seg_n = SEG_9;
         default: seg_n = SEG_DASH;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/m_seg7_scanner.sv
// +-------------------------------------------------------------------------+
// | m_seg7_scanner : six-digit HH:MM:SS multiplexed display scanner          |
// | Build option COLON_BLINK_EN: colon dots follow the synchronised 1 Hz.    |
// | Rev 1.0  : initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module m_seg7_scanner
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16
)(
   input  logic  clk,
   input  logic  rst_n,
   seg7_if.slave disp
);

   localparam int                CNT_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] c_blank_pre = CNT_W'(BLANK_CYC - 1);
   localparam slot_t             c_slot_last = slot_t'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] r_cnt;
   slot_t            r_slot;
   scan_state_t      r_state;
   scan_state_t      w_state_next;
   logic             r_first;
   logic [23:0]      r_snap;
   logic [3:0]       w_bcd;
   logic [6:0]       w_dec_n;
   logic             w_colon_on;
   logic             w_wrap;
   logic             w_frame_end;
   logic [5:0]       w_dig_n;
   logic [6:0]       w_seg_n;
   logic             w_dp_n;
   logic [5:0]       r_dig_n;
   logic [6:0]       r_seg_n;
   logic             r_dp_n;

   assign w_wrap      = (r_cnt == c_cnt_last);
   assign w_frame_end = w_wrap && (r_slot == c_slot_last);

   // r_first makes the first edge after reset take the snapshot for frame 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_slot  <= '0;
         r_first <= 1'b1;
         r_snap  <= '0;
      end else begin
         r_first <= 1'b0;
         if (w_wrap) begin
            r_cnt  <= '0;
            r_slot <= w_frame_end ? slot_t'(0) : slot_t'(r_slot + 3'd1);
         end else begin
            r_cnt  <= r_cnt + 1'b1;
         end
         if (r_first || w_frame_end) begin
            r_snap <= {disp.h1, disp.h0, disp.m1, disp.m0, disp.s1, disp.s0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BLANK;
      end else begin
         r_state <= w_state_next;
      end
   end

`ifdef COLON_BLINK_EN
   logic [1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], disp.one_hz_clk};
      end
   end

   assign w_colon_on = r_sync[1];
`else
   assign w_colon_on = 1'b1;
`endif

   always_comb begin
      w_bcd = r_snap[3:0];
      case (r_slot)
         3'd0:    w_bcd = r_snap[23:20];
         3'd1:    w_bcd = r_snap[19:16];
         3'd2:    w_bcd = r_snap[15:12];
         3'd3:    w_bcd = r_snap[11:8];
         3'd4:    w_bcd = r_snap[7:4];
         default: w_bcd = r_snap[3:0];
      endcase
   end

   m_bcd_to_seg7 u_dec (
      .bcd   (w_bcd),
      .seg_n (w_dec_n)
   );

   always_comb begin
      w_state_next = r_state;
      w_dig_n      = DIG_OFF;
      w_seg_n      = SEG_OFF;
      w_dp_n       = 1'b1;
      case (r_state)
         BLANK: begin
            if (r_cnt == c_blank_pre) begin
               w_state_next = DRIVE;
            end
         end
         DRIVE: begin
            if (w_wrap) begin
               w_state_next = BLANK;
            end
            w_dig_n = ~(6'b100000 >> r_slot);
            w_seg_n = w_dec_n;
            w_dp_n  = ~(((r_slot == 3'd1) || (r_slot == 3'd3)) && w_colon_on);
         end
         default: w_state_next = BLANK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dig_n <= DIG_OFF;
         r_seg_n <= SEG_OFF;
         r_dp_n  <= 1'b1;
      end else begin
         r_dig_n <= w_dig_n;
         r_seg_n <= w_seg_n;
         r_dp_n  <= w_dp_n;
      end
   end

   assign disp.dig_n = r_dig_n;
   assign disp.seg_n = r_seg_n;
   assign disp.dp_n  = r_dp_n;

endmodule

`default_nettype wire

// File: tb/tb_m_seg7_scanner.sv
// +-------------------------------------------------------------------------+
// | tb_m_seg7_scanner : scoreboard bench for m_seg7_scanner (8/2 timing)     |
// | Rev 1.0  : initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_m_seg7_scanner;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   seg7_if bus ();

   m_seg7_scanner #(
      .SCAN_DIV  (8),
      .BLANK_CYC (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .disp  (bus)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          t        = 0;
   logic [23:0] m_snap   = '0;
   logic        hz_d1    = 1'b0;
   logic        hz_d2    = 1'b0;
   logic [13:0] sb[$];

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   // Expected {dig_n, seg_n, dp_n} after edge tt (tt = 1 is the first edge after release)
   function automatic logic [13:0] ref_out(input int tt);
      int          pos;
      int          k;
      logic [5:0]  dig;
      logic        colon;
      logic        dp;
      pos = (tt - 1) % 8;
      k   = ((tt - 1) / 8) % 6;
      if (pos < 2) return {6'h3F, 7'h7F, 1'b1};
      dig        = 6'h3F;
      dig[5 - k] = 1'b0;
      colon      = (k == 1) || (k == 3);
`ifdef COLON_BLINK_EN
      dp = !(colon && hz_d2);
`else
      dp = !colon;
`endif
      return {dig, ref_seg(m_snap[4 * (5 - k) +: 4]), dp};
   endfunction

   task automatic set_digits(input logic [23:0] v);
      {bus.h1, bus.h0, bus.m1, bus.m0, bus.s1, bus.s0} = v;
   endtask

   task automatic model_reset();
      t     = 0;
      hz_d1 = 1'b0;
      hz_d2 = 1'b0;
   endtask

   task automatic tick(output logic [13:0] obs);
      t = t + 1;
      sb.push_back(ref_out(t));
      if (t == 1 || (t % 48) == 0) begin
         m_snap = {bus.h1, bus.h0, bus.m1, bus.m0, bus.s1, bus.s0};
      end
      hz_d2 = hz_d1;
      hz_d1 = bus.one_hz_clk;
      @(posedge clk);
      #1;
      obs = {bus.dig_n, bus.seg_n, bus.dp_n};
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus.one_hz_clk = 1'b1;
      set_digits(24'h123456);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.dig_n !== 6'h3F) $display("FAIL reset_dig actual=%h required=3f", bus.dig_n);
      else n_pass++;
      n_checks++;
      if (bus.seg_n !== 7'h7F) $display("FAIL reset_seg actual=%h required=7f", bus.seg_n);
      else n_pass++;
      n_checks++;
      if (bus.dp_n !== 1'b1) $display("FAIL reset_dp actual=%b required=1", bus.dp_n);
      else n_pass++;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_frame();
      logic [13:0] obs;
      logic [13:0] exp_v;
      for (int i = 0; i < 48; i++) begin
         tick(obs);
         exp_v = sb.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL frame t=%0d actual=%h required=%h", t, obs, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_snapshot();
      logic [13:0] obs;
      logic [13:0] exp_v;
      for (int i = 0; i < 96; i++) begin
         tick(obs);
         exp_v = sb.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL snapshot t=%0d actual=%h required=%h", t, obs, exp_v);
         else n_pass++;
         if (((t - 1) % 48) == 17 && i < 48) bus.s0 = 4'd7;
      end
   endtask

   task automatic test_invalid();
      logic [13:0] obs;
      logic [13:0] exp_v;
      bus.m1 = 4'hB;
      for (int i = 0; i < 96; i++) begin
         tick(obs);
         exp_v = sb.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL invalid t=%0d actual=%h required=%h", t, obs, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_colon();
      logic [13:0] obs;
      logic [13:0] exp_v;
      bus.one_hz_clk = 1'b0;
      for (int i = 0; i < 144; i++) begin
         if (i == 96) bus.one_hz_clk = 1'b1;
         tick(obs);
         exp_v = sb.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL colon t=%0d actual=%h required=%h", t, obs, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [13:0] obs;
      logic [13:0] exp_v;
      for (int i = 0; i < 48 && ((t - 1) % 48) != 28; i++) begin
         tick(obs);
         exp_v = sb.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL pre_reset t=%0d actual=%h required=%h", t, obs, exp_v);
         else n_pass++;
      end
      n_checks++;
      if (((t - 1) % 48) != 28) $display("FAIL reach_slot3 actual=%0d required=28", (t - 1) % 48);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.dig_n, bus.seg_n, bus.dp_n} !== {6'h3F, 7'h7F, 1'b1})
         $display("FAIL async_reset actual=%h required=%h", {bus.dig_n, bus.seg_n, bus.dp_n},
                  {6'h3F, 7'h7F, 1'b1});
      else n_pass++;
      set_digits(24'h205908);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 48; i++) begin
         tick(obs);
         exp_v = sb.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL restart t=%0d actual=%h required=%h", t, obs, exp_v);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_snapshot();
      test_invalid();
      test_colon();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
